// File: rtl/proc_phase_sequencer.sv
// Six-phase instruction sequencer for the multi-cycle MIPS-style core.
// A single clock drives everything; each phase gets a one-cycle enable strobe.
module proc_phase_sequencer #(
    parameter int PC_WIDTH = 12
) (
    input  logic                clock,
    input  logic                reset,
    output logic [PC_WIDTH-1:0] address_imem,
    input  logic [31:0]         imem_q,
    output logic [4:0]          ctrl_readRegA,
    output logic [4:0]          ctrl_readRegB,
    input  logic [31:0]         data_readRegA,
    input  logic [31:0]         data_readRegB,
    input  logic                pc_load,
    input  logic [PC_WIDTH-1:0] pc_target,
    output logic [31:0]         q,
    output logic [31:0]         ALU_reg_test,
    output logic [31:0]         ALU_reg_imm,
    output logic                instr_valid,
    output logic                dmem_wren,
    output logic                dmem_rden,
    output logic                ctrl_writeEnable,
    output logic [4:0]          ctrl_writeReg
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_READ,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [31:0]         op_a_q, op_a_d;
    logic [31:0]         op_b_q, op_b_d;
    logic [4:0]          wreg_q, wreg_d;
    logic                valid_q, valid_d;
    logic                wren_q, wren_d;
    logic                rden_q, rden_d;
    logic                we_q, we_d;

    logic [4:0]  opcode;
    logic        uses_imm;
    logic        writes_reg;
    logic [31:0] imm_ext;

    assign opcode     = instr_q[31:27];
    assign uses_imm   = (opcode == OP_ADDI) || (opcode == OP_SW) || (opcode == OP_LW);
    assign writes_reg = (opcode == OP_RTYPE) || (opcode == OP_ADDI) || (opcode == OP_LW);
    assign imm_ext    = {{15{instr_q[16]}}, instr_q[16:0]};

    // Register addresses must reach the regfile in DECODE, before the word is latched.
    always_comb begin
        if (state_q == S_DECODE) begin
            ctrl_readRegA = imem_q[21:17];
            ctrl_readRegB = imem_q[16:12];
        end else begin
            ctrl_readRegA = instr_q[21:17];
            ctrl_readRegB = instr_q[16:12];
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        wreg_d  = wreg_q;
        valid_d = 1'b0;
        wren_d  = 1'b0;
        rden_d  = 1'b0;
        we_d    = 1'b0;
        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                instr_d = imem_q;
                wreg_d  = imem_q[26:22];
                state_d = S_READ;
            end
            S_READ: begin
                op_a_d  = data_readRegA;
                op_b_d  = uses_imm ? imm_ext : data_readRegB;
                valid_d = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                pc_d    = pc_load ? pc_target : pc_q + PC_WIDTH'(1);
                wren_d  = (opcode == OP_SW);
                rden_d  = (opcode == OP_LW);
                state_d = S_MEM;
            end
            S_MEM: begin
                we_d    = writes_reg;
                state_d = S_WB;
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Strobes are computed one phase early so they are clean registered pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            wreg_q  <= '0;
            valid_q <= 1'b0;
            wren_q  <= 1'b0;
            rden_q  <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            wreg_q  <= wreg_d;
            valid_q <= valid_d;
            wren_q  <= wren_d;
            rden_q  <= rden_d;
            we_q    <= we_d;
        end
    end

    assign address_imem     = pc_q;
    assign q                = instr_q;
    assign ALU_reg_test     = op_a_q;
    assign ALU_reg_imm      = op_b_q;
    assign ctrl_writeReg    = wreg_q;
    assign instr_valid      = valid_q;
    assign dmem_wren        = wren_q;
    assign dmem_rden        = rden_q;
    assign ctrl_writeEnable = we_q;

endmodule

// File: tb/tb_proc_phase_sequencer.sv
// Bench for proc_phase_sequencer: directed instruction table, an aborted
// instruction, then random instructions checked against an instruction-level model.
module tb_proc_phase_sequencer;

    logic        clock;
    logic        reset;
    logic [11:0] address_imem;
    logic [31:0] imem_q;
    logic [4:0]  ctrl_readRegA;
    logic [4:0]  ctrl_readRegB;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        pc_load;
    logic [11:0] pc_target;
    logic [31:0] q;
    logic [31:0] ALU_reg_test;
    logic [31:0] ALU_reg_imm;
    logic        instr_valid;
    logic        dmem_wren;
    logic        dmem_rden;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;

    proc_phase_sequencer #(.PC_WIDTH(12)) dut (
        .clock            (clock),
        .reset            (reset),
        .address_imem     (address_imem),
        .imem_q           (imem_q),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .pc_load          (pc_load),
        .pc_target        (pc_target),
        .q                (q),
        .ALU_reg_test     (ALU_reg_test),
        .ALU_reg_imm      (ALU_reg_imm),
        .instr_valid      (instr_valid),
        .dmem_wren        (dmem_wren),
        .dmem_rden        (dmem_rden),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] imem [0:4095];
    logic [31:0] regs [0:31];

    // Synchronous-read memories: data appears one cycle after the address.
    always @(posedge clock) begin
        imem_q        <= imem[address_imem];
        data_readRegA <= regs[ctrl_readRegA];
        data_readRegB <= regs[ctrl_readRegB];
    end

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  load_mask;
        logic [11:0] target;
        logic        abort;
        logic        check_imm;
        logic [31:0] exp_test;
        logic [31:0] exp_imm;
        logic [4:0]  exp_wreg;
        logic        exp_wren;
        logic        exp_rden;
        logic        exp_we;
        logic [11:0] exp_next_pc;
    } vec_t;

    int          checks;
    int          errors;
    logic [11:0] modelPc;
    vec_t        tbl [8];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] strobes();
        return {28'd0, instr_valid, dmem_wren, dmem_rden, ctrl_writeEnable};
    endfunction

    // Instruction-level reference: what one instruction should produce overall.
    function automatic vec_t buildVec(input logic [31:0] instr, input logic [5:0] mask,
                                      input logic [11:0] tgt, input logic [11:0] pc);
        vec_t v;
        int   immv;
        int   op;
        op   = int'(instr[31:27]);
        immv = int'(instr[16:0]);
        if (immv >= 65536) immv = immv - 131072;
        v.instr       = instr;
        v.load_mask   = mask;
        v.target      = tgt;
        v.abort       = 1'b0;
        v.check_imm   = (op == 0) || (op == 5) || (op == 7) || (op == 8);
        v.exp_test    = regs[instr[21:17]];
        v.exp_imm     = (op == 0) ? regs[instr[16:12]] : 32'(immv);
        v.exp_wreg    = instr[26:22];
        v.exp_wren    = (op == 7);
        v.exp_rden    = (op == 8);
        v.exp_we      = (op == 0) || (op == 5) || (op == 8);
        v.exp_next_pc = mask[3] ? tgt : 12'((int'(pc) + 1) % 4096);
        return v;
    endfunction

    // Runs one instruction from its FETCH cycle, checking each phase at the negedge.
    task automatic applyStimulus(input vec_t v);
        imem[modelPc] = v.instr;
        pc_target     = v.target;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            case (k)
                0: begin
                    checkOutput("fetch_addr", 32'(address_imem), 32'(modelPc));
                    checkOutput("fetch_strobes", strobes(), 32'h0);
                end
                1: begin
                    checkOutput("decode_rega", 32'(ctrl_readRegA), 32'(v.instr[21:17]));
                    checkOutput("decode_regb", 32'(ctrl_readRegB), 32'(v.instr[16:12]));
                    checkOutput("decode_strobes", strobes(), 32'h0);
                end
                2: begin
                    checkOutput("read_rega", 32'(ctrl_readRegA), 32'(v.instr[21:17]));
                    checkOutput("read_strobes", strobes(), 32'h0);
                end
                3: begin
                    checkOutput("exec_strobes", strobes(), 32'h8);
                    checkOutput("exec_q", q, v.instr);
                    checkOutput("exec_alu_test", ALU_reg_test, v.exp_test);
                    if (v.check_imm) checkOutput("exec_alu_imm", ALU_reg_imm, v.exp_imm);
                    checkOutput("exec_wreg", 32'(ctrl_writeReg), 32'(v.exp_wreg));
                end
                4: begin
                    checkOutput("mem_strobes", strobes(), {29'd0, v.exp_wren, v.exp_rden, 1'b0});
                    checkOutput("mem_next_pc", 32'(address_imem), 32'(v.exp_next_pc));
                end
                default: begin
                    checkOutput("wb_strobes", strobes(), {31'd0, v.exp_we});
                    checkOutput("wb_wreg", 32'(ctrl_writeReg), 32'(v.exp_wreg));
                    checkOutput("wb_q_held", q, v.instr);
                end
            endcase
            if (v.abort && k == 4) begin
                reset   = 1'b1;
                pc_load = 1'b0;
                @(negedge clock);
                checkOutput("abort_strobes", strobes(), 32'h0);
                checkOutput("abort_addr", 32'(address_imem), 32'h0);
                checkOutput("abort_q", q, 32'h0);
                checkOutput("abort_wreg", 32'(ctrl_writeReg), 32'h0);
                @(posedge clock);
                #1 reset = 1'b0;
                modelPc  = 12'h000;
                return;
            end
            pc_load = v.load_mask[k];
        end
        modelPc = v.exp_next_pc;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        modelPc   = 12'h000;
        reset     = 1'b1;
        pc_load   = 1'b0;
        pc_target = 12'h000;
        for (int i = 0; i < 4096; i++) imem[i] = 32'h0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[1] = 32'd5;
        regs[2] = 32'd3;

        tbl[0] = '{32'h28400005, 6'b000000, 12'h000, 1'b0, 1'b1, 32'h0, 32'h5,        5'd1,  1'b0, 1'b0, 1'b1, 12'h001};
        tbl[1] = '{32'h00C22000, 6'b000000, 12'h000, 1'b0, 1'b1, 32'h5, 32'h3,        5'd3,  1'b0, 1'b0, 1'b1, 12'h002};
        tbl[2] = '{32'h2DC10000, 6'b000000, 12'h000, 1'b0, 1'b1, 32'h0, 32'hFFFF0000, 5'd23, 1'b0, 1'b0, 1'b1, 12'h003};
        tbl[3] = '{32'h3A800001, 6'b001000, 12'h010, 1'b0, 1'b1, 32'h0, 32'h1,        5'd10, 1'b1, 1'b0, 1'b0, 12'h010};
        tbl[4] = '{32'h43000001, 6'b000100, 12'h0AB, 1'b0, 1'b1, 32'h0, 32'h1,        5'd12, 1'b0, 1'b1, 1'b1, 12'h011};
        tbl[5] = '{32'hF8000000, 6'b001000, 12'hFFF, 1'b0, 1'b0, 32'h0, 32'h0,        5'd0,  1'b0, 1'b0, 1'b0, 12'hFFF};
        tbl[6] = '{32'h01042000, 6'b110111, 12'h123, 1'b0, 1'b1, 32'h3, 32'h3,        5'd4,  1'b0, 1'b0, 1'b1, 12'h000};
        tbl[7] = '{32'h43000001, 6'b000000, 12'h000, 1'b1, 1'b1, 32'h0, 32'h1,        5'd12, 1'b0, 1'b1, 1'b1, 12'h001};

        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            checkOutput("reset_addr", 32'(address_imem), 32'h0);
            checkOutput("reset_strobes", strobes(), 32'h0);
            checkOutput("reset_q", q, 32'h0);
            checkOutput("reset_alu_test", ALU_reg_test, 32'h0);
            checkOutput("reset_alu_imm", ALU_reg_imm, 32'h0);
            checkOutput("reset_wreg", 32'(ctrl_writeReg), 32'h0);
        end
        @(posedge clock);
        #1 reset = 1'b0;

        for (int i = 0; i < 8; i++) applyStimulus(tbl[i]);

        $display("[TB] directed table done, starting random instructions");
        for (int i = 1; i < 32; i++) regs[i] = $urandom;
        for (int n = 0; n < 60; n++) begin
            logic [4:0]  ops [5];
            logic [31:0] instr;
            ops[0] = 5'd0;
            ops[1] = 5'd5;
            ops[2] = 5'd7;
            ops[3] = 5'd8;
            ops[4] = 5'($urandom_range(9, 31));
            instr  = {ops[$urandom_range(0, 4)], 27'($urandom)};
            applyStimulus(buildVec(instr, 6'($urandom), 12'($urandom), modelPc));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
